// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe -- pipelined floating-point adder/subtractor with RNE rounding.
// Ports:
//   clk, n_rst             clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    operand handshake; transfer when both high
//   mode                   0 = op1 + op2, 1 = op1 - op2
//   op1, op2               operands {sign, exponent, fraction}
//   out_valid / out_ready  result handshake; transfer when both high
//   result                 rounded sum/difference
//   overflow               result saturated to +/-inf
//   underflow              nonzero result flushed to +0
//   zero                   result is +/-0
// Pipeline: input capture -> S1 unpack/swap/align -> S2 add/sub -> S3 normalise/round/pack.
// Any stall freezes every stage, so bubbles are held in place.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         underflow,
  output logic         zero
);
  localparam int M   = MAN_W + 1;      // significand incl. hidden bit
  localparam int X   = M + 3;          // significand + guard/round/sticky
  localparam int EW  = EXP_W + 2;      // signed exponent working width
  localparam int LZW = $clog2(X + 1);

  logic w_adv;
  assign w_adv    = ~(out_valid & ~out_ready);
  assign in_ready = w_adv;

  // input capture
  logic         r_v0, r_mode0;
  logic [W-1:0] r_op1, r_op2;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_v0 <= 1'b0; r_mode0 <= 1'b0; r_op1 <= '0; r_op2 <= '0;
    end else if (w_adv) begin
      r_v0 <= in_valid;
      if (in_valid) begin
        r_op1 <= op1; r_op2 <= op2; r_mode0 <= mode;
      end
    end
  end

  // S1: unpack, swap so |A| >= |B|, align B
  logic               w_s1, w_s2, w_z1, w_z2, w_swap, w_sa;
  logic [EXP_W-1:0]   w_e1, w_e2, w_ea, w_eb, w_diff;
  logic [M-1:0]       w_m1, w_m2, w_ma, w_mb;
  logic [W-2:0]       w_mag1, w_mag2;
  logic [2*X-1:0]     w_wide;
  logic [X-1:0]       w_mb_al;

  always_comb begin
    w_s1   = r_op1[W-1];
    w_s2   = r_op2[W-1] ^ r_mode0;
    w_e1   = r_op1[W-2:MAN_W];
    w_e2   = r_op2[W-2:MAN_W];
    w_z1   = (w_e1 == '0);
    w_z2   = (w_e2 == '0);
    w_m1   = w_z1 ? '0 : {1'b1, r_op1[MAN_W-1:0]};
    w_m2   = w_z2 ? '0 : {1'b1, r_op2[MAN_W-1:0]};
    w_mag1 = w_z1 ? '0 : r_op1[W-2:0];
    w_mag2 = w_z2 ? '0 : r_op2[W-2:0];
    w_swap = (w_mag2 > w_mag1);
    w_sa   = w_swap ? w_s2 : w_s1;
    w_ea   = w_swap ? w_e2 : w_e1;
    w_eb   = w_swap ? w_e1 : w_e2;
    w_ma   = w_swap ? w_m2 : w_m1;
    w_mb   = w_swap ? w_m1 : w_m2;
    w_diff = w_ea - w_eb;
    // Shift in a double-width window; everything falling below the
    // guard/round positions collapses into the sticky bit.
    w_wide = {w_mb, 3'b000, {X{1'b0}}} >> w_diff;
    if (32'(w_diff) >= 32'(MAN_W + 3))
      w_mb_al = {{(X-1){1'b0}}, |w_mb};
    else
      w_mb_al = {w_wide[2*X-1:X+1], w_wide[X] | (|w_wide[X-1:0])};
  end

  logic             r_v1, r_s1, r_sub1, r_bz1, r_bzs1, r_inf1, r_infs1;
  logic [EXP_W-1:0] r_e1;
  logic [X-1:0]     r_ma1, r_mb1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_v1 <= 1'b0; r_s1 <= 1'b0; r_sub1 <= 1'b0; r_bz1 <= 1'b0; r_bzs1 <= 1'b0;
      r_inf1 <= 1'b0; r_infs1 <= 1'b0; r_e1 <= '0; r_ma1 <= '0; r_mb1 <= '0;
    end else if (w_adv) begin
      r_v1    <= r_v0;
      r_s1    <= w_sa;
      r_sub1  <= w_s1 ^ w_s2;
      r_bz1   <= w_z1 & w_z2;
      r_bzs1  <= w_s1 & w_s2;
      r_inf1  <= (&w_e1) | (&w_e2);
      r_infs1 <= (&w_e1) ? w_s1 : w_s2;
      r_e1    <= w_ea;
      r_ma1   <= {w_ma, 3'b000};
      r_mb1   <= w_mb_al;
    end
  end

  // S2: add/subtract extended significands (A >= B, so never negative)
  logic [X:0] w_sum;
  assign w_sum = r_sub1 ? ({1'b0, r_ma1} - {1'b0, r_mb1})
                        : ({1'b0, r_ma1} + {1'b0, r_mb1});

  logic             r_v2, r_s2, r_bz2, r_bzs2, r_inf2, r_infs2;
  logic [EXP_W-1:0] r_e2;
  logic [X:0]       r_sum2;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_v2 <= 1'b0; r_s2 <= 1'b0; r_bz2 <= 1'b0; r_bzs2 <= 1'b0;
      r_inf2 <= 1'b0; r_infs2 <= 1'b0; r_e2 <= '0; r_sum2 <= '0;
    end else if (w_adv) begin
      r_v2 <= r_v1; r_s2 <= r_s1; r_bz2 <= r_bz1; r_bzs2 <= r_bzs1;
      r_inf2 <= r_inf1; r_infs2 <= r_infs1; r_e2 <= r_e1; r_sum2 <= w_sum;
    end
  end

  // S3: normalise, round to nearest even, pack
  logic                  w_found, w_rup, w_ov, w_uf, w_z;
  logic [LZW-1:0]        w_lz;
  logic [X-1:0]          w_norm;
  logic signed [EW-1:0]  w_exp3, w_fexp;
  logic [M:0]            w_rnd;
  logic [MAN_W-1:0]      w_frac;
  logic [W-1:0]          w_res;

  always_comb begin
    w_lz    = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < X; i++) begin
      if (!w_found && r_sum2[X-1-i]) begin
        w_lz    = LZW'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    if (r_sum2[X]) begin
      w_norm = {r_sum2[X:2], r_sum2[1] | r_sum2[0]};
      w_exp3 = $signed({2'b00, r_e2}) + EW'(1);
    end else begin
      w_norm = r_sum2[X-1:0] << w_lz;
      w_exp3 = $signed({2'b00, r_e2}) - EW'(w_lz);
    end
    w_rup  = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
    w_rnd  = {1'b0, w_norm[X-1:3]} + {{M{1'b0}}, w_rup};
    w_fexp = w_exp3 + {{(EW-1){1'b0}}, w_rnd[M]};
    w_frac = w_rnd[M] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];

    w_res = {r_s2, w_fexp[EXP_W-1:0], w_frac};
    w_ov  = 1'b0;
    w_uf  = 1'b0;
    w_z   = 1'b0;
    if (r_inf2) begin
      w_res = {r_infs2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_ov  = 1'b1;
    end else if (r_sum2 == '0) begin
      w_res = {r_bz2 & r_bzs2, {(W-1){1'b0}}};
      w_z   = 1'b1;
    end else if (w_fexp >= (1 << EXP_W) - 1) begin
      w_res = {r_s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_ov  = 1'b1;
    end else if (w_fexp <= 0) begin
      w_res = '0;
      w_uf  = 1'b1;
      w_z   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid <= 1'b0; result <= '0; overflow <= 1'b0; underflow <= 1'b0; zero <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_v2;
      if (r_v2) begin
        result <= w_res; overflow <= w_ov; underflow <= w_uf; zero <= w_z;
      end
    end
  end

endmodule
